// File: rtl/auction_sequencer_if.sv
// ----------------------------------------------------------------------------
// auction_sequencer_if
// Purpose : groups the control, bid and result signals of auction_sequencer.
// Signals :
//   start, abort              round control (master -> slave)
//   bid, bid_valid, bid_ready bid handshake
//   result_valid, result_ack  result handshake
//   winner, winning_bid,
//   second_bid                result payload (registered in the slave)
//   busy                      round in progress (COLLECT or DONE)
//   dbg_state                 FSM state for observation (0 IDLE, 1 COLLECT, 2 DONE)
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high; the source holds its data stable while valid is high
// and ready is low. The result side is held by the slave until result_ack.
// ----------------------------------------------------------------------------
interface auction_sequencer_if #(
    parameter int N = 2,
    parameter int W = 2
);
    logic         start;
    logic         abort;
    logic [W-1:0] bid;
    logic         bid_valid;
    logic         bid_ready;
    logic         result_valid;
    logic         result_ack;
    logic [N-1:0] winner;
    logic [W-1:0] winning_bid;
    logic [W-1:0] second_bid;
    logic         busy;
    logic [1:0]   dbg_state;

    modport master (
        output start, abort, bid, bid_valid, result_ack,
        input  bid_ready, result_valid, winner, winning_bid, second_bid,
               busy, dbg_state
    );

    modport slave (
        input  start, abort, bid, bid_valid, result_ack,
        output bid_ready, result_valid, winner, winning_bid, second_bid,
               busy, dbg_state
    );
endinterface

// File: rtl/auction_sequencer.sv
// ----------------------------------------------------------------------------
// auction_sequencer
// Purpose : bid-serial Vickrey auction. Accepts one W-bit bid per cycle from
//           2**N bidders in index order, tracks highest bid, second-highest
//           bid and winner index, and presents them on a result handshake
//           held until acknowledged.
// Ports   :
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    auction_sequencer_if.slave (control, bid and result handshakes)
// ----------------------------------------------------------------------------
module auction_sequencer #(
    parameter int N = 2,
    parameter int W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    auction_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [N-1:0] r_count;
    logic [N-1:0] r_winner;
    logic [W-1:0] r_max;
    logic [W-1:0] r_second;

    logic         w_start;
    logic         w_accept;
    logic         w_last;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort wins over every other input outside IDLE and
    // also suppresses a simultaneous start in IDLE.
    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_accept = 1'b0;
        w_last   = (r_count == {N{1'b1}});
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_next  = S_COLLECT;
                    w_start = 1'b1;
                end
            end
            S_COLLECT: begin
                if (bus.abort) begin
                    w_next = S_IDLE;
                end else if (bus.bid_valid) begin
                    w_accept = 1'b1;
                    if (w_last) begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.abort || bus.result_ack) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Running registers double as the result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_winner <= '0;
            r_max    <= '0;
            r_second <= '0;
        end else if (w_start) begin
            r_count  <= '0;
            r_winner <= '0;
            r_max    <= '0;
            r_second <= '0;
        end else if (w_accept) begin
            // count wraps to 0 on the last bid, ready for the next round
            r_count <= r_count + N'(1);
            if (bus.bid > r_max) begin
                r_second <= r_max;
                r_max    <= bus.bid;
                r_winner <= r_count;
            end else if (bus.bid > r_second) begin
                // includes a tie with max: winner stays, second becomes max
                r_second <= bus.bid;
            end
        end else if (bus.abort && (r_state != S_IDLE)) begin
            r_count <= '0;
        end
    end

    assign bus.bid_ready    = (r_state == S_COLLECT);
    assign bus.result_valid = (r_state == S_DONE);
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.winner       = r_winner;
    assign bus.winning_bid  = r_max;
    assign bus.second_bid   = r_second;
    assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_auction_sequencer.sv
module tb_auction_sequencer;

  localparam int N = 2;
  localparam int W = 4;

  logic clk;
  logic rst_n;

  auction_sequencer_if #(.N(N), .W(W)) bus ();

  auction_sequencer #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input logic [1:0] w,
                              input logic [3:0] b, input logic [3:0] s);
    check({tag, " result_valid"}, 32'(bus.result_valid), 32'd1);
    check({tag, " winner"},       32'(bus.winner),       32'(w));
    check({tag, " winning_bid"},  32'(bus.winning_bid),  32'(b));
    check({tag, " second_bid"},   32'(bus.second_bid),   32'(s));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] bids;    // bid k in bits [4k+3:4k], k=0 first
    logic [1:0]  exp_win;
    logic [3:0]  exp_bid;
    logic [3:0]  exp_sec;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  function automatic logic [15:0] pack4(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] c, input logic [3:0] d);
    return {d, c, b, a};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.bid        = '0;
    bus.bid_valid  = 1'b0;
    bus.result_ack = 1'b0;
  endtask

  task automatic start_round();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Full round without stalls, result check and acknowledge.
  task automatic run_round(input string tag, input vec_t v);
    logic [15:0] bv;
    bv = v.bids;
    start_round();
    check({tag, " busy after start"},  32'(bus.busy),      32'd1);
    check({tag, " bid_ready"},         32'(bus.bid_ready), 32'd1);
    check({tag, " state collect"},     32'(bus.dbg_state), 32'd1);
    for (int k = 0; k < 4; k++) begin
      bus.bid_valid = 1'b1;
      bus.bid       = bv[4*k +: 4];
      tick();
      if (k < 3) check({tag, " early result_valid"}, 32'(bus.result_valid), 32'd0);
    end
    bus.bid_valid = 1'b0;
    check_result(tag, v.exp_win, v.exp_bid, v.exp_sec);
    check({tag, " bid_ready in done"}, 32'(bus.bid_ready), 32'd0);
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
    check({tag, " result_valid after ack"}, 32'(bus.result_valid), 32'd0);
    check({tag, " busy after ack"},         32'(bus.busy),         32'd0);
    check({tag, " state idle after ack"},   32'(bus.dbg_state),    32'd0);
  endtask

  task automatic abort_sequence();
    start_round();
    bus.bid_valid = 1'b1;
    bus.bid = 4'd8;  tick();
    bus.bid = 4'd12; tick();
    bus.bid_valid = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort state idle", 32'(bus.dbg_state), 32'd0);
    check("abort busy",       32'(bus.busy),      32'd0);
    for (int c = 0; c < 4; c++) begin
      bus.bid_valid = 1'b1;
      bus.bid       = 4'd15;
      tick();
      check("abort result_valid stays low", 32'(bus.result_valid), 32'd0);
    end
    bus.bid_valid = 1'b0;
  endtask

  // ---------------- main test ----------------
  initial begin
    drive_idle();
    rst_n = 1'b0;
    vecs[0] = '{pack4(3, 9, 5, 7),     2'd1, 4'd9,  4'd7};
    vecs[1] = '{pack4(6, 2, 6, 1),     2'd0, 4'd6,  4'd6};
    vecs[2] = '{pack4(0, 0, 0, 0),     2'd0, 4'd0,  4'd0};
    vecs[3] = '{pack4(15, 15, 15, 15), 2'd0, 4'd15, 4'd15};
    vecs[4] = '{pack4(5, 1, 1, 9),     2'd3, 4'd9,  4'd5};
    vecs[5] = '{pack4(2, 8, 8, 3),     2'd1, 4'd8,  4'd8};
    vecs[6] = '{pack4(1, 2, 3, 4),     2'd3, 4'd4,  4'd3};
    vecs[7] = '{pack4(4, 3, 2, 1),     2'd0, 4'd4,  4'd3};
    vecs[8] = '{pack4(7, 0, 7, 12),    2'd3, 4'd12, 4'd7};

    #22;
    check("reset bid_ready",    32'(bus.bid_ready),    32'd0);
    check("reset result_valid", 32'(bus.result_valid), 32'd0);
    check("reset busy",         32'(bus.busy),         32'd0);
    check("reset winner",       32'(bus.winner),       32'd0);
    check("reset winning_bid",  32'(bus.winning_bid),  32'd0);
    check("reset second_bid",   32'(bus.second_bid),   32'd0);
    rst_n = 1'b1;
    tick();

    // start together with abort in IDLE: stay IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    drive_idle();
    check("start+abort idle state", 32'(bus.dbg_state), 32'd0);

    for (int i = 0; i < NV; i++) begin
      if (i == 6) abort_sequence();
      run_round($sformatf("vec%0d", i), vecs[i]);
    end

    // bid_valid in IDLE leaves the last result (vec8) unchanged
    for (int c = 0; c < 3; c++) begin
      bus.bid_valid = 1'b1;
      bus.bid       = 4'd15;
      tick();
    end
    bus.bid_valid = 1'b0;
    check("idle bid winner",      32'(bus.winner),      32'd3);
    check("idle bid winning_bid", 32'(bus.winning_bid), 32'd12);
    check("idle bid second_bid",  32'(bus.second_bid),  32'd7);
    check("idle bid state",       32'(bus.dbg_state),   32'd0);

    // stalls: 1,15 then 3 idle cycles, then 4,15; result held without ack
    start_round();
    bus.bid_valid = 1'b1;
    bus.bid = 4'd1;  tick();
    bus.bid = 4'd15; tick();
    bus.bid_valid = 1'b0;
    bus.bid = 4'd0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall bid_ready", 32'(bus.bid_ready), 32'd1);
      check("stall state",     32'(bus.dbg_state), 32'd1);
    end
    bus.bid_valid = 1'b1;
    bus.bid = 4'd4;  tick();
    check("stall early result_valid", 32'(bus.result_valid), 32'd0);
    bus.bid = 4'd15; tick();
    bus.bid_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      // start and stray bids during DONE must be ignored
      bus.start     = 1'b1;
      bus.bid_valid = 1'b1;
      bus.bid       = 4'd14;
      check_result("stall hold", 2'd1, 4'd15, 4'd15);
      tick();
    end
    drive_idle();
    check_result("stall hold end", 2'd1, 4'd15, 4'd15);
    // ack and abort together in DONE: IDLE
    bus.result_ack = 1'b1;
    bus.abort      = 1'b1;
    tick();
    drive_idle();
    check("ack+abort result_valid", 32'(bus.result_valid), 32'd0);
    check("ack+abort state",        32'(bus.dbg_state),    32'd0);

    // asynchronous reset mid-COLLECT
    start_round();
    bus.bid_valid = 1'b1;
    bus.bid = 4'd9; tick();
    bus.bid = 4'd3; tick();
    bus.bid_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async rst bid_ready",   32'(bus.bid_ready),   32'd0);
    check("async rst busy",        32'(bus.busy),        32'd0);
    check("async rst winner",      32'(bus.winner),      32'd0);
    check("async rst winning_bid", 32'(bus.winning_bid), 32'd0);
    check("async rst second_bid",  32'(bus.second_bid),  32'd0);
    #2 rst_n = 1'b1;
    tick();

    // a clean round after reset still works
    run_round("post reset", vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
